// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: arbiter state type, UART byte width, grant index width helper.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: first valid requester above last_grant, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
// Ports:
//   req_valid_i  - pending-request vector
//   last_grant_i - index served most recently (lowest priority on this pick)
//   grant_oh_o   - one-hot pick, all zero when nothing is pending
//   grant_idx_o  - index of the pick (0 when nothing is pending)
//   any_valid_o  - at least one request pending
module uart_rr_pick import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [GW-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [GW-1:0]      grant_idx_o,
  output logic               any_valid_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int                   sel;

  always_comb begin
    // Rotate so that bit 0 of rot is requester last_grant+1; the doubled
    // vector provides the wrap-around without a modulo on the index.
    dbl   = {req_valid_i, req_valid_i} >> (int'(last_grant_i) + 1);
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sel   = (int'(last_grant_i) + 1 + k) % NUM_REQ;
      end
    end
    grant_oh_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_oh_o[j] = found && (j == sel);
    end
    grant_idx_o = GW'(sel);
  end

  assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers.
// Latency: accept -> tx_start 1 cycle when tx_busy=0; tx_done -> next accept 1 cycle.
// Backpressure: req_ready only in IDLE; ISSUE stalls on tx_busy; one byte in flight.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_data    - per-requester byte offer, byte i at req_data[i*8 +: 8]
//   req_ready             - one-hot combinational acceptance strobe
//   tx_start/tx_data      - one-cycle frame start and the latched byte
//   tx_busy/tx_done       - transmitter occupied / stop bit completed pulse
//   grant_id, active      - requester being served, FSM not IDLE
//   timeout_err           - watchdog abort pulse
// Optional feature: define UART_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog
// (TIMEOUT_CYC cycles); otherwise timeout_err is tied low.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_BYTE_W,
  parameter int TIMEOUT_CYC = 4096,
  localparam int GW         = grant_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [GW-1:0]             grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  pick_data;
  logic               start_fire;
  logic               abort;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_oh_o   (pick_oh),
    .grant_idx_o  (pick_idx),
    .any_valid_o  (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  // Held at zero throughout ISSUE, so the first WAIT_DONE cycle sees 0.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == WAIT_DONE && !abort) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end
  end

  // A tx_done arriving on the limit cycle still completes the frame normally.
  assign abort = (state_q == WAIT_DONE) && !tx_done && (wd_cnt_q == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    req_ready    = '0;
    start_fire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready    = pick_oh;
          last_grant_d = pick_idx;
          grant_id_d   = pick_idx;
          tx_data_d    = pick_data;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          start_fire = 1'b1;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A byte offered during reset would be dropped, so never acknowledge it.
    if (rst) begin
      req_ready  = '0;
      start_fire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx_start    = start_fire;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = (state_q != IDLE);
  assign timeout_err = abort && !rst;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  logic model_busy = 1'b0, model_done = 1'b0;
  logic busy_force = 1'b0, spur_done = 1'b0, no_done = 1'b0;
  int   frame_len = 10;

  assign tx_busy = model_busy | busy_force;
  assign tx_done = model_done | spur_done;

  int   ntests = 0, nfail = 0, cyc = 0;
  int   hs_count = 0, start_count = 0, to_count = 0;
  int   last_done_cyc = -100, last_start_cyc = 0, to_cyc = 0;
  logic gap_chk = 1'b0, prev_start = 1'b0;

  int         acc_q[$];
  logic [9:0] start_q[$];

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    logic [9:0] e;
    int id;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != 4'b0) begin
          hs_count++;
          if (acc_q.size() == 0) begin
            chk("unexpected_accept", 32'(req_ready), 32'd0);
          end else begin
            id = acc_q.pop_front();
            chk("accept_onehot", 32'(req_ready), 32'd1 << id);
            if (gap_chk) chk("done_to_accept_gap", 32'(cyc - last_done_cyc), 32'd1);
          end
        end
        if (tx_start) begin
          start_count++;
          chk("start_not_back_to_back", 32'(prev_start), 32'd0);
          if (start_q.size() == 0) begin
            chk("unexpected_start", 32'(tx_start), 32'd0);
          end else begin
            e = start_q.pop_front();
            chk("start_grant_id", 32'(grant_id), 32'(e[9:8]));
            chk("start_tx_data", 32'(tx_data), 32'(e[7:0]));
          end
          last_start_cyc = cyc;
        end
        if (tx_done && active) last_done_cyc = cyc;
        if (timeout_err) begin
          to_count++;
          to_cyc = cyc;
        end
      end
      prev_start = tx_start;
    end
  end

  // Transmitter model: busy for frame_len cycles after tx_start, then tx_done.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (frame_len - 1) @(posedge clk);
        #1 if (!no_done) model_done = 1'b1;
        @(posedge clk); #1 model_done = 1'b0; model_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b0;
    acc_q.delete();
    start_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("handshake_within_budget", 32'(hs_count >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (active && n < budget);
    chk("idle_within_budget", 32'(active), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_active"},      32'(active),      32'd0);
    chk({tag, "_tx_start"},    32'(tx_start),    32'd0);
    chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
    chk({tag, "_grant_id"},    32'(grant_id),    32'd0);
    chk({tag, "_tx_data"},     32'(tx_data),     32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int s, h0, s0;
    rst = 1'b1;
    req_valid = 4'b0;
    req_data = 32'h0;

    // Reset state.
    do_reset();
    @(negedge clk);
    chk_reset_outputs("reset");

    // Single request, long frame.
    frame_len = 160;
    req_data = 32'h0000_0055;
    acc_q.push_back(0);
    start_q.push_back({2'd0, 8'h55});
    @(posedge clk); #1 req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready_same_cycle", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_start_next_cycle", 32'(tx_start), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'h55);
    wait_idle(400);
    chk("t1_start_to_done", 32'(last_done_cyc - last_start_cyc), 32'd160);

    // Fairness: all four held valid.
    do_reset();
    frame_len = 10;
    req_data = 32'hA3A2_A1A0;
    acc_q = '{0, 1, 2, 3, 0};
    start_q = '{{2'd0, 8'hA0}, {2'd1, 8'hA1}, {2'd2, 8'hA2}, {2'd3, 8'hA3}, {2'd0, 8'hA0}};
    h0 = hs_count;
    @(posedge clk); #1 req_valid = 4'b1111;
    wait_hs(h0 + 1, 20);
    gap_chk = 1'b1;
    wait_hs(h0 + 5, 200);
    @(posedge clk); #1 req_valid = 4'b0000;
    gap_chk = 1'b0;
    wait_idle(100);
    chk("t2_all_started", 32'(start_q.size()), 32'd0);

    // Busy hold for 20 cycles after acceptance.
    do_reset();
    busy_force = 1'b1;
    req_data = 32'h3C00_0000;
    acc_q.push_back(3);
    start_q.push_back({2'd3, 8'h3C});
    @(posedge clk); #1 req_valid = 4'b1000;
    @(negedge clk);
    chk("t3_ready", 32'(req_ready), 32'h8);
    @(posedge clk); #1 req_valid = 4'b0000;
    s = 0;
    repeat (20) begin
      @(negedge clk);
      s += int'(tx_start);
    end
    chk("t3_no_start_while_busy", 32'(s), 32'd0);
    @(posedge clk); #1 busy_force = 1'b0;
    @(negedge clk);
    chk("t3_start_when_free", 32'(tx_start), 32'd1);
    chk("t3_tx_data_held", 32'(tx_data), 32'h3C);
    wait_idle(50);

    // Spurious tx_done in IDLE, then a withdrawn request during a frame.
    s0 = start_count;
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    @(negedge clk);
    chk("t4_spurious_done_idle", 32'(active), 32'd0);
    chk("t4_spurious_no_start", 32'(start_count - s0), 32'd0);
    frame_len = 20;
    req_data = 32'h00EE_0011;
    acc_q.push_back(0);
    start_q.push_back({2'd0, 8'h11});
    h0 = hs_count;
    @(posedge clk); #1 req_valid = 4'b0001;
    @(posedge clk); #1 req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1 req_valid = 4'b0100;
    repeat (4) @(posedge clk);
    #1 req_valid = 4'b0000;
    wait_idle(100);
    repeat (5) @(negedge clk);
    chk("t4_one_handshake", 32'(hs_count - h0), 32'd1);
    chk("t4_one_start", 32'(start_count - s0), 32'd1);

    // Reset during WAIT_DONE.
    frame_len = 50;
    req_data = 32'h0000_7700;
    acc_q.push_back(1);
    start_q.push_back({2'd1, 8'h77});
    s0 = start_count;
    @(posedge clk); #1 req_valid = 4'b0010;
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    chk("t5_started", 32'(start_count - s0), 32'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("t5_mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    req_data = 32'hC300_00C0;
    acc_q = '{0, 3};
    start_q = '{{2'd0, 8'hC0}, {2'd3, 8'hC3}};
    h0 = hs_count;
    @(posedge clk); #1 req_valid = 4'b1001;
    wait_hs(h0 + 1, 20);
    @(posedge clk); #1 req_valid = 4'b1000;
    wait_hs(h0 + 2, 300);
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_idle(100);
    chk("t5_all_started", 32'(start_q.size()), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog abort after 16 cycles in WAIT_DONE.
    do_reset();
    frame_len = 10;
    no_done = 1'b1;
    req_data = 32'h0099_00B0;
    acc_q.push_back(2);
    start_q.push_back({2'd2, 8'h99});
    h0 = hs_count;
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_hs(h0 + 1, 20);
    @(posedge clk); #1 req_valid = 4'b0101;
    s = 0;
    while (to_count == 0 && s < 60) begin
      @(negedge clk); #1;
      s++;
    end
    acc_q.push_back(0);
    start_q.push_back({2'd0, 8'hB0});
    no_done = 1'b0;
    chk("t6_timeout_seen", 32'(to_count), 32'd1);
    chk("t6_timeout_delay", 32'(to_cyc - last_start_cyc), 32'd17);
    wait_hs(h0 + 2, 20);
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_idle(100);
    chk("t6_single_pulse", 32'(to_count), 32'd1);
    chk("t6_all_started", 32'(start_q.size()), 32'd0);
`else
    chk("no_timeout_err", 32'(to_count), 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
